// File: rtl/crc_pkg.sv
// Shared definitions for the CRC frame packer: FSM state encoding and the
// CRC-16 polynomial and seed value.
package crc_pkg;

    // IDLE: no frame open, PAYLOAD: frame open, CRC: CRC word waiting for the output slot
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CRC     = 2'd2
    } state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'h0000;

endpackage

// File: rtl/crc16_step.sv
// One 16-bit CRC step: sixteen MSB-first shift-left / conditional-XOR rounds
// with CRC_POLY. The caller XORs the running CRC with the data word first.
module crc16_step
    import crc_pkg::*;
(
    input  logic [15:0] data,
    output logic [15:0] result
);

    logic [15:0] acc;

    // Unrolled shift register division by the generator polynomial
    always_comb begin
        acc = data;
        for (int i = 0; i < 16; i++) begin
            if (acc[15]) begin
                acc = {acc[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                acc = {acc[14:0], 1'b0};
            end
        end
        result = acc;
    end

endmodule

// File: rtl/crc_frame_packer.sv
// Streams payload words through a single output register and appends a
// CRC-16 word (marked with out_last) after each frame. A frame ends on
// in_last or when MAX_WORDS words have been taken, the latter reported on len_err.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the sender keeps data/last stable while valid is high and ready is low.
module crc_frame_packer
    import crc_pkg::*;
#(
    parameter int MAX_WORDS = 256
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic        frame_done,
    output logic        len_err
);

    localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] crc_q;
    logic [15:0] count_q;
    logic [15:0] count_inc;
    logic [15:0] crc_seed;
    logic [15:0] crc_nxt;
    logic        slot_free;
    logic        in_hs;
    logic        hit_max;
    logic        frame_end;
    logic        load_crc;

    // The output register can take a new word if empty or being drained now
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state_q != ST_CRC) && slot_free;
    assign in_hs     = in_valid && in_ready;

    // A new frame always starts from the seed, whatever crc_q holds
    assign crc_seed  = (state_q == ST_IDLE) ? CRC_INIT : crc_q;
    assign count_inc = count_q + 16'd1;
    assign hit_max   = (count_inc == MAX_CNT);
    assign frame_end = in_last || hit_max;

    crc16_step u_step (
        .data   (crc_seed ^ in_data),
        .result (crc_nxt)
    );

    // State register
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and CRC-slot load decision
    always_comb begin
        state_d  = state_q;
        load_crc = 1'b0;
        case (state_q)
            ST_IDLE, ST_PAYLOAD: begin
                if (in_hs) begin
                    state_d = frame_end ? ST_CRC : ST_PAYLOAD;
                end
            end
            ST_CRC: begin
                if (slot_free) begin
                    load_crc = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register, running CRC, word count and status pulses
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            crc_q      <= CRC_INIT;
            count_q    <= 16'd0;
            out_data   <= 16'h0000;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            frame_done <= out_valid && out_ready && out_last;
            len_err    <= in_hs && hit_max && !in_last;
            if (in_hs) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
                out_last  <= 1'b0;
                crc_q     <= crc_nxt;
                count_q   <= count_inc;
            end else if (load_crc) begin
                out_data  <= crc_q;
                out_valid <= 1'b1;
                out_last  <= 1'b1;
                crc_q     <= CRC_INIT;
                count_q   <= 16'd0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_crc_frame_packer.sv
// Bench for crc_frame_packer with MAX_WORDS=4: constant CRC vector table,
// directed stall / length-limit / reset / back-to-back sequences, and random
// frames checked against a bit-serial CRC reference and an expected-word queue.
module tb_crc_frame_packer;

    localparam int MAXW = 4;

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        int          n;
        logic [15:0] crc;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b1;
    logic [15:0] in_data = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic        frame_done;
    logic        len_err;

    crc_frame_packer #(.MAX_WORDS(MAXW)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .len_err    (len_err)
    );

    // clock
    always #5 clk_in = ~clk_in;

    int          checks = 0;
    int          failures = 0;
    logic [16:0] exp_q[$];        // {last, data} in expected output order
    logic [15:0] crc_seen_q[$];
    int          out_cyc_q[$];
    int          cyc = 0;
    logic [15:0] m_crc = 16'h0000;
    int          m_len = 0;
    bit          fd_pend = 0;
    bit          le_pend = 0;
    int          le_count = 0;
    bit          rand_ready = 0;
    logic [16:0] exp_w;
    vec_t        tbl[6];

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=completion", name);
    endtask

    // CRC of a message as polynomial division, one message bit at a time
    function automatic logic [15:0] ref_step(input logic [15:0] rem_in, input logic [15:0] w);
        logic [15:0] rem;
        logic        fb;
        rem = rem_in;
        for (int b = 15; b >= 0; b--) begin
            fb  = rem[15] ^ w[b];
            rem = {rem[14:0], 1'b0};
            if (fb) rem = rem ^ 16'h1021;
        end
        return rem;
    endfunction

    // scoreboard: consumes output handshakes, builds expectations from input handshakes
    always @(negedge clk_in) begin
        if (rst_n) begin
            cyc++;
            check_bit("frame_done", frame_done, fd_pend);
            check_bit("len_err", len_err, le_pend);
            fd_pend = 0;
            le_pend = 0;
            if (len_err) le_count++;
            if (out_valid && out_ready) begin
                out_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_extra actual=%h required=no_word", {out_last, out_data});
                end else begin
                    exp_w = exp_q.pop_front();
                    check_word("out_word", {out_last, out_data}, exp_w);
                    fd_pend = exp_w[16];
                end
                if (out_last) crc_seen_q.push_back(out_data);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, in_data});
                m_crc = ref_step(m_crc, in_data);
                m_len++;
                if (in_last || m_len == MAXW) begin
                    exp_q.push_back({1'b1, m_crc});
                    if (!in_last) le_pend = 1;
                    m_crc = 16'h0000;
                    m_len = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_word(input logic [15:0] d, input logic last);
        bit hs;
        hs = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk_in);
            hs = in_ready;
            tick();
            if (hs) break;
        end
        if (!hs) fail_timeout("send_word");
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int g = 0; g < 500; g++) begin
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) fail_timeout("drain");
        tick();
        tick();
    endtask

    task automatic clear_model();
        exp_q.delete();
        m_crc   = 16'h0000;
        m_len   = 0;
        fd_pend = 0;
        le_pend = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_bit({tag, "_out_valid"}, out_valid, 1'b0);
        check_bit({tag, "_out_last"}, out_last, 1'b0);
        check_word({tag, "_out_data"}, {1'b0, out_data}, 17'h0);
        check_bit({tag, "_frame_done"}, frame_done, 1'b0);
        check_bit({tag, "_len_err"}, len_err, 1'b0);
    endtask

    // watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        // reset block
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        check_bit("reset_in_ready", in_ready, 1'b1);
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        tick();

        // vector table: frame words and the CRC word that must follow
        tbl[0] = '{16'h0001, 16'h0000, 1, 16'h1021};
        tbl[1] = '{16'h8000, 16'h0000, 1, 16'h1B98};
        tbl[2] = '{16'h0001, 16'h0000, 2, 16'h3730};
        tbl[3] = '{16'h0000, 16'h0001, 2, 16'h1021};
        tbl[4] = '{16'h0000, 16'h8000, 2, 16'h1B98};
        tbl[5] = '{16'h0000, 16'h0000, 1, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            crc_seen_q.delete();
            send_word(tbl[i].w0, tbl[i].n == 1);
            if (tbl[i].n == 2) send_word(tbl[i].w1, 1'b1);
            drain();
            check_word("tbl_crc_count", 17'(crc_seen_q.size()), 17'd1);
            if (crc_seen_q.size() > 0) check_word("tbl_crc", {1'b0, crc_seen_q[0]}, {1'b0, tbl[i].crc});
        end

        // backpressure for 5 cycles with the next word already offered
        send_word(16'hA5A5, 1'b0);
        in_data   = 16'h5A5A;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            check_word("stall_out_data", {1'b0, out_data}, 17'h0A5A5);
            check_bit("stall_out_valid", out_valid, 1'b1);
            check_bit("stall_in_ready", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        send_word(16'h5A5A, 1'b0);
        send_word(16'h1234, 1'b1);
        drain();

        // length limit: 6 words without in_last, then a closing word
        c0 = le_count;
        crc_seen_q.delete();
        for (int i = 1; i <= 6; i++) send_word(16'(i * 16'h0101), 1'b0);
        send_word(16'h0707, 1'b1);
        drain();
        check_word("maxw_len_err_count", 17'(le_count - c0), 17'd1);
        check_word("maxw_crc_count", 17'(crc_seen_q.size()), 17'd2);

        // reset while a frame is open
        send_word(16'h1111, 1'b0);
        send_word(16'h2222, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        clear_model();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        crc_seen_q.delete();
        send_word(16'h0001, 1'b1);
        drain();
        check_word("post_reset_crc_count", 17'(crc_seen_q.size()), 17'd1);
        if (crc_seen_q.size() > 0) check_word("post_reset_crc", {1'b0, crc_seen_q[0]}, 17'h01021);

        // two back-to-back frames with no bubble in the output stream
        crc_seen_q.delete();
        out_cyc_q.delete();
        send_word(16'h0001, 1'b0);
        send_word(16'h0000, 1'b1);
        send_word(16'h0000, 1'b0);
        send_word(16'h8000, 1'b1);
        drain();
        check_word("b2b_out_count", 17'(out_cyc_q.size()), 17'd6);
        for (int i = 1; i < out_cyc_q.size(); i++)
            check_word("b2b_gap", 17'(out_cyc_q[i] - out_cyc_q[i-1]), 17'd1);
        check_word("b2b_crc_count", 17'(crc_seen_q.size()), 17'd2);
        if (crc_seen_q.size() == 2) begin
            check_word("b2b_crc0", {1'b0, crc_seen_q[0]}, 17'h03730);
            check_word("b2b_crc1", {1'b0, crc_seen_q[1]}, 17'h01B98);
        end

        // random frames, random gaps, random downstream backpressure
        rand_ready = 1;
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int w = 0; w < len; w++) begin
                if ($urandom_range(0, 3) == 0) tick();
                send_word(16'($urandom), w == len - 1);
            end
        end
        rand_ready = 0;
        out_ready  = 1'b1;
        drain();
        check_word("final_exp_q_empty", 17'(exp_q.size()), 17'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crc_frame_packer.md
CRC_FRAME_PACKER -- requirements
Module: crc_frame_packer

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256, meaning the maximum payload words per frame (range 2..65535).
REQ-002 SHALL have port clk_in, input, 1, the single system clock; all logic is rising-edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-004 SHALL have port in_data, input, 16, the payload word.
REQ-005 SHALL have port in_valid, input, 1, meaning in_data is valid.
REQ-006 SHALL have port in_last, input, 1, marking the last payload word of a frame.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts the input word this cycle.
REQ-008 SHALL have port out_data, output, 16, carrying a payload word or the CRC word.
REQ-009 SHALL have port out_valid, output, 1, meaning out_data is valid.
REQ-010 SHALL have port out_last, output, 1, high only with the CRC word.
REQ-011 SHALL have port out_ready, input, 1, the downstream accept signal.
REQ-012 SHALL have port frame_done, output, 1, a one-cycle pulse when the CRC word handshake completes.
REQ-013 SHALL have port len_err, output, 1, a one-cycle pulse when a frame is force-terminated at MAX_WORDS.

Function
REQ-014 SHALL define a handshake as valid&&ready in the same cycle, with data held stable by the sender until then.
REQ-015 SHALL use the CRC: poly 0x1021 (1+x^5+x^12+x^16), MSB-first, no reflection, init 0x0000, no final XOR, one 16-bit word per step: crc_next = F(crc XOR word), where F applies 16 shift-left/conditional-XOR-0x1021 steps.
REQ-016 SHALL implement the FSM states IDLE (no frame open), PAYLOAD (frame open), and CRC (CRC word pending).
REQ-017 SHALL have an output register; a slot is free when !out_valid || out_ready.
REQ-018 SHALL drive in_ready = (state != CRC) && slot free, combinationally.
REQ-019 SHALL, on an input handshake, load out_data<=in_data, out_valid<=1, out_last<=0, update crc, and increment the word count, giving one cycle of latency input to output.
REQ-020 SHALL, on IDLE with an input handshake, go to PAYLOAD, seeding the CRC from 0x0000.
REQ-021 SHALL, on a handshake with in_last=1, or when the word count reaches MAX_WORDS, go to CRC; a single-word frame goes IDLE->CRC directly.
REQ-022 SHALL, in the MAX_WORDS termination case without in_last, pulse len_err in the cycle after that handshake; later words start a new frame.
REQ-023 SHALL, in CRC with a free slot, load out_data<=crc, out_valid<=1, out_last<=1, clear crc and the count, and return to IDLE.
REQ-024 SHALL pulse frame_done in the cycle after the CRC word handshake (out_valid&&out_ready&&out_last).
REQ-025 SHALL clear out_valid when out_ready is high and no new word is loaded; under backpressure the output holds.
REQ-026 SHALL keep the payload and CRC words of consecutive frames back-to-back; no bubble is needed beyond the single CRC slot.

Reset
REQ-027 SHALL, on asserting rst_n=0, immediately force state=IDLE, crc=0x0000, count=0, out_valid=0, out_last=0, out_data=0x0000, frame_done=0, len_err=0.
REQ-028 SHALL abort any partial frame on reset mid-frame with no CRC emitted, and SHALL treat the first word after release as a new frame.

Structure
REQ-029 SHALL place the FSM state enum, CRC_POLY=16'h1021 and CRC_INIT=16'h0000 in the shared package crc_pkg.
REQ-030 SHALL implement F as the sub-module crc16_step, combinational, 16-bit in, 16-bit out.

Verification
REQ-031 SHALL cover: single word 0x0001, in_last=1 -> out 0x0001 then CRC 0x1021 with out_last, then frame_done pulse.
REQ-032 SHALL cover: single word 0x8000 -> CRC 0x1B98; frame 0x0001,0x0000 -> CRC 0x3730.
REQ-033 SHALL cover: out_ready=0 for 5 cycles mid-frame -> out_data stable, in_ready=0, no words lost or duplicated.
REQ-034 SHALL cover: MAX_WORDS=4 with 6 words and no in_last -> CRC after word 4 and a len_err pulse, then words 5-6 open a new frame.
REQ-035 SHALL cover: rst_n low during PAYLOAD -> all outputs are 0 immediately, and the next frame 0x0001 gives CRC 0x1021.
REQ-036 SHALL cover: two back-to-back frames with out_ready=1 -> one CRC slot between them, and the second CRC is independent of the first.
